// File: rtl/dynamic_phase_multi.sv
// Multi-channel MMCM dynamic phase-shift sequencer.
// Each channel runs its own IDLE/STEP/WAIT/ERROR machine, which drives PSEN/PSINCDEC
// and counts PSDONE acknowledges into a signed accumulated-phase tracker.
// A per-channel watchdog trips when PSDONE does not come back in time.
module dynamic_phase_multi #(
  parameter int NUM_CH       = 2,
  parameter int PHASE_BITS   = 12,
  parameter int CUR_BITS     = 16,
  parameter int TIMEOUT_BITS = 8
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [NUM_CH-1:0]            ps_start,
  input  logic [NUM_CH-1:0]            ps_abs,
  input  logic [NUM_CH*PHASE_BITS-1:0] ps_phase,
  input  logic [NUM_CH-1:0]            ps_clear,
  input  logic [NUM_CH-1:0]            clock_locked,
  output logic [NUM_CH-1:0]            ps_en,
  output logic [NUM_CH-1:0]            ps_inc,
  input  logic [NUM_CH-1:0]            ps_done,
  output logic [NUM_CH-1:0]            ps_active,
  output logic [NUM_CH-1:0]            ps_error,
  output logic [NUM_CH*CUR_BITS-1:0]   ps_current
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_STEP  = 2'd1,
    ST_WAIT  = 2'd2,
    ST_ERROR = 2'd3
  } state_e;

  // Delta and remaining-step count need one bit more than the tracker so that
  // an absolute target minus the current phase can never overflow.
  localparam int DW = CUR_BITS + 1;
  localparam logic [DW-1:0]           DW_ZERO  = {DW{1'b0}};
  localparam logic [DW-1:0]           DW_ONE   = {{(DW-1){1'b0}}, 1'b1};
  localparam logic [CUR_BITS-1:0]     CUR_ZERO = {CUR_BITS{1'b0}};
  localparam logic [CUR_BITS-1:0]     CUR_ONE  = {{(CUR_BITS-1){1'b0}}, 1'b1};
  localparam logic [TIMEOUT_BITS-1:0] WD_ZERO  = {TIMEOUT_BITS{1'b0}};
  localparam logic [TIMEOUT_BITS-1:0] WD_ONE   = {{(TIMEOUT_BITS-1){1'b0}}, 1'b1};
  localparam logic [TIMEOUT_BITS-1:0] WD_MAX   = {TIMEOUT_BITS{1'b1}};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    state_e                  state_q, state_d;
    logic                    en_q, en_d;
    logic                    inc_q, inc_d;
    logic                    active_q, active_d;
    logic                    error_q, error_d;
    logic [CUR_BITS-1:0]     cur_q, cur_d;
    logic [DW-1:0]           rem_q, rem_d;
    logic [TIMEOUT_BITS-1:0] wd_q, wd_d;
    logic [PHASE_BITS-1:0]   phase_s;
    logic [DW-1:0]           req_s;
    logic [DW-1:0]           delta_s;
    logic [DW-1:0]           mag_s;

    // Sign-extend the request and form the signed step count and its magnitude.
    always_comb begin
      phase_s = ps_phase[g*PHASE_BITS +: PHASE_BITS];
      req_s   = {{(DW-PHASE_BITS){phase_s[PHASE_BITS-1]}}, phase_s};
      if (ps_abs[g]) begin
        delta_s = req_s - {cur_q[CUR_BITS-1], cur_q};
      end else begin
        delta_s = req_s;
      end
      if (delta_s[DW-1]) begin
        mag_s = (~delta_s) + DW_ONE;
      end else begin
        mag_s = delta_s;
      end
    end

    // Per-channel sequencer: next-state and next-output computation.
    always_comb begin
      state_d  = state_q;
      en_d     = 1'b0;
      inc_d    = inc_q;
      active_d = active_q;
      error_d  = error_q;
      cur_d    = cur_q;
      rem_d    = rem_q;
      wd_d     = wd_q;
      case (state_q)
        ST_IDLE: begin
          if (ps_start[g]) begin
            if (!clock_locked[g]) begin
              state_d  = ST_ERROR;
              active_d = 1'b1;
              error_d  = 1'b1;
              inc_d    = 1'b0;
            end else if (delta_s == DW_ZERO) begin
              state_d = ST_IDLE;
            end else begin
              state_d  = ST_STEP;
              en_d     = 1'b1;
              inc_d    = ~delta_s[DW-1];
              active_d = 1'b1;
              rem_d    = mag_s;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_STEP: begin
          // The PSEN pulse is already on the pins this cycle; lock loss still aborts.
          wd_d = WD_ZERO;
          if (!clock_locked[g]) begin
            state_d = ST_ERROR;
            error_d = 1'b1;
            inc_d   = 1'b0;
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (!clock_locked[g]) begin
            state_d = ST_ERROR;
            error_d = 1'b1;
            inc_d   = 1'b0;
          end else if (ps_done[g]) begin
            if (inc_q) begin
              cur_d = cur_q + CUR_ONE;
            end else begin
              cur_d = cur_q - CUR_ONE;
            end
            rem_d = rem_q - DW_ONE;
            if (rem_q == DW_ONE) begin
              state_d  = ST_IDLE;
              active_d = 1'b0;
            end else begin
              state_d = ST_STEP;
              en_d    = 1'b1;
            end
          end else if (wd_q == WD_MAX) begin
            state_d = ST_ERROR;
            error_d = 1'b1;
            inc_d   = 1'b0;
          end else begin
            wd_d = wd_q + WD_ONE;
          end
        end
        ST_ERROR: begin
          // Phase is unknown after a fault, so the tracker restarts from zero.
          if (ps_clear[g]) begin
            state_d  = ST_IDLE;
            active_d = 1'b0;
            error_d  = 1'b0;
            cur_d    = CUR_ZERO;
          end else begin
            state_d = ST_ERROR;
          end
        end
        default: begin
          state_d  = ST_IDLE;
          active_d = 1'b0;
          error_d  = 1'b0;
          inc_d    = 1'b0;
        end
      endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clock) begin
      if (!reset_n) begin
        state_q  <= ST_IDLE;
        en_q     <= 1'b0;
        inc_q    <= 1'b0;
        active_q <= 1'b0;
        error_q  <= 1'b0;
        cur_q    <= CUR_ZERO;
        rem_q    <= DW_ZERO;
        wd_q     <= WD_ZERO;
      end else begin
        state_q  <= state_d;
        en_q     <= en_d;
        inc_q    <= inc_d;
        active_q <= active_d;
        error_q  <= error_d;
        cur_q    <= cur_d;
        rem_q    <= rem_d;
        wd_q     <= wd_d;
      end
    end

    assign ps_en[g]                            = en_q;
    assign ps_inc[g]                           = inc_q;
    assign ps_active[g]                        = active_q;
    assign ps_error[g]                         = error_q;
    assign ps_current[g*CUR_BITS +: CUR_BITS]  = cur_q;
  end

endmodule

// File: tb/tb_dynamic_phase_multi.sv
// Scoreboard bench for dynamic_phase_multi: a behavioural model predicts each run's
// outcome (final phase, pulse count, direction) at issue time; a monitor compares
// when a channel finishes a run, enters ERROR, or leaves ERROR.
module tb_dynamic_phase_multi;
  localparam int NCH = 2;
  localparam int PB  = 12;
  localparam int CB  = 16;
  localparam int TB  = 4;

  localparam int K_RUN = 0;
  localparam int K_ERR = 1;
  localparam int K_CLR = 2;
  localparam int M_NORMAL  = 0;
  localparam int M_TIMEOUT = 1;
  localparam int M_DROP    = 2;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic              reset_n;
  logic [NCH-1:0]    ps_start, ps_abs, ps_clear, clock_locked, ps_done;
  logic [NCH-1:0]    ps_en, ps_inc, ps_active, ps_error;
  logic [NCH*PB-1:0] ps_phase;
  logic [NCH*CB-1:0] ps_current;

  dynamic_phase_multi #(
    .NUM_CH(NCH), .PHASE_BITS(PB), .CUR_BITS(CB), .TIMEOUT_BITS(TB)
  ) dut (
    .clock(clock), .reset_n(reset_n), .ps_start(ps_start), .ps_abs(ps_abs),
    .ps_phase(ps_phase), .ps_clear(ps_clear), .clock_locked(clock_locked),
    .ps_en(ps_en), .ps_inc(ps_inc), .ps_done(ps_done), .ps_active(ps_active),
    .ps_error(ps_error), .ps_current(ps_current)
  );

  typedef struct {
    int ch;
    int kind;
    int cur;
    int pulses;
    int inc;
    int gap;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad   = 0;
  int model_cur[NCH];
  logic [NCH-1:0] lock_want;
  int withhold[NCH];
  int drop_at[NCH];
  int seen_pulses[NCH];
  int last_pulse_cyc[NCH];
  int cyc = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got=%0d required=%0d", name, $signed(act), $signed(req));
    end
  endtask

  function automatic int wrap_cur(input int v);
    logic signed [CB-1:0] t;
    t = CB'(v);
    return int'(t);
  endfunction

  function automatic int sext_req(input int v);
    logic signed [PB-1:0] t;
    t = PB'(v);
    return int'(t);
  endfunction

  function automatic logic [63:0] cur_of(input int ch);
    logic signed [CB-1:0] c;
    c = ps_current[ch*CB +: CB];
    return 64'(c);
  endfunction

  function automatic int find_ch(input int ch);
    foreach (exp_q[i]) if (exp_q[i].ch == ch) return i;
    return -1;
  endfunction

  function automatic int count_ch(input int ch);
    int n = 0;
    foreach (exp_q[i]) if (exp_q[i].ch == ch) n++;
    return n;
  endfunction

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Predict the outcome of a start request and drive it (takes effect on the next tick).
  task automatic arm(input int ch, input bit is_abs, input int phase, input int mode, input int k);
    exp_t e;
    int req, delta, dir;
    req   = sext_req(phase);
    delta = is_abs ? req - model_cur[ch] : req;
    dir   = (delta > 0) ? 1 : -1;
    e.ch = ch; e.gap = 0; e.inc = (delta > 0) ? 1 : 0;
    if (!lock_want[ch]) begin
      e.kind = K_ERR; e.cur = model_cur[ch]; e.pulses = 0; e.inc = 0;
      exp_q.push_back(e);
    end else if (delta != 0) begin
      if (mode == M_TIMEOUT) begin
        e.kind = K_ERR; e.pulses = 1; e.cur = model_cur[ch]; e.gap = 1 + (1 << TB);
      end else if (mode == M_DROP) begin
        e.kind = K_ERR; e.pulses = k; e.cur = wrap_cur(model_cur[ch] + dir * (k - 1));
      end else begin
        e.kind = K_RUN; e.pulses = (delta < 0) ? -delta : delta;
        e.cur = wrap_cur(model_cur[ch] + delta);
        model_cur[ch] = e.cur;
      end
      exp_q.push_back(e);
    end
    ps_start[ch] = 1'b1;
    ps_abs[ch]   = is_abs;
    ps_phase[ch*PB +: PB] = PB'(phase);
  endtask

  task automatic fire();
    tick();
    ps_start = '0;
  endtask

  task automatic wait_q(input int ch);
    int n = 0;
    while (count_ch(ch) != 0 && n < 3000) begin
      tick();
      n++;
    end
    if (count_ch(ch) != 0) begin
      total++;
      bad++;
      $display("FAIL wait_ch%0d: pending=%0d required=0", ch, count_ch(ch));
      for (int i = exp_q.size() - 1; i >= 0; i--) if (exp_q[i].ch == ch) exp_q.delete(i);
    end
    tick();
    tick();
  endtask

  task automatic clear_ch(input int ch);
    exp_t e;
    e.ch = ch; e.kind = K_CLR; e.cur = 0; e.pulses = 0; e.inc = 0; e.gap = 0;
    exp_q.push_back(e);
    model_cur[ch] = 0;
    ps_clear[ch] = 1'b1;
    tick();
    ps_clear[ch] = 1'b0;
    wait_q(ch);
  endtask

  task automatic wait_pulses(input int ch, input int n);
    int c = 0;
    while (seen_pulses[ch] < n && c < 200) begin
      tick();
      c++;
    end
    check($sformatf("ch%0d_reach_pulses", ch), 64'(seen_pulses[ch] >= n), 64'(1));
  endtask

  // MMCM responder: PSDONE 1..3 cycles after each PSEN, optional withholding and lock drop.
  initial begin
    int done_cnt[NCH];
    bit killed[NCH];
    ps_done = '0;
    clock_locked = '0;
    for (int ch = 0; ch < NCH; ch++) begin
      done_cnt[ch] = 0;
      killed[ch] = 1'b0;
    end
    forever begin
      @(posedge clock);
      #1;
      for (int ch = 0; ch < NCH; ch++) begin
        ps_done[ch] = 1'b0;
        if (drop_at[ch] == 0) killed[ch] = 1'b0;
        if (done_cnt[ch] > 0) begin
          done_cnt[ch]--;
          if (done_cnt[ch] == 0) begin
            ps_done[ch] = 1'b1;
            if (drop_at[ch] != 0 && seen_pulses[ch] == drop_at[ch]) killed[ch] = 1'b1;
          end
        end
        if (ps_en[ch] && withhold[ch] == 0) done_cnt[ch] = $urandom_range(1, 3);
        clock_locked[ch] = lock_want[ch] & ~killed[ch];
      end
    end
  end

  // Monitor: pulse-level checks and event-driven scoreboard comparisons.
  initial begin
    bit prev_en[NCH];
    bit prev_act[NCH];
    bit prev_err[NCH];
    for (int ch = 0; ch < NCH; ch++) begin
      prev_en[ch] = 1'b0; prev_act[ch] = 1'b0; prev_err[ch] = 1'b0;
    end
    forever begin
      @(negedge clock);
      cyc++;
      if (!reset_n) begin
        for (int ch = 0; ch < NCH; ch++) begin
          prev_en[ch] = 1'b0; prev_act[ch] = 1'b0; prev_err[ch] = 1'b0;
          seen_pulses[ch] = 0;
        end
      end else begin
        for (int ch = 0; ch < NCH; ch++) begin
          int idx;
          int kind;
          if (ps_en[ch]) begin
            check($sformatf("ch%0d_en_single", ch), 64'(prev_en[ch]), 64'(0));
            seen_pulses[ch]++;
            last_pulse_cyc[ch] = cyc;
            idx = find_ch(ch);
            check($sformatf("ch%0d_pulse_expected", ch), 64'(idx >= 0), 64'(1));
            if (idx >= 0) check($sformatf("ch%0d_inc", ch), 64'(ps_inc[ch]), 64'(exp_q[idx].inc));
          end
          kind = -1;
          if (ps_error[ch] && !prev_err[ch]) kind = K_ERR;
          else if (!ps_error[ch] && prev_err[ch]) kind = K_CLR;
          else if (!ps_active[ch] && prev_act[ch]) kind = K_RUN;
          if (kind >= 0) begin
            idx = find_ch(ch);
            check($sformatf("ch%0d_event_expected", ch), 64'(idx >= 0), 64'(1));
            if (idx >= 0) begin
              check($sformatf("ch%0d_event_kind", ch), 64'(kind), 64'(exp_q[idx].kind));
              check($sformatf("ch%0d_current", ch), cur_of(ch), 64'(exp_q[idx].cur));
              if (exp_q[idx].kind != K_CLR)
                check($sformatf("ch%0d_pulses", ch), 64'(seen_pulses[ch]), 64'(exp_q[idx].pulses));
              if (exp_q[idx].gap != 0)
                check($sformatf("ch%0d_timeout_gap", ch), 64'(cyc - last_pulse_cyc[ch]), 64'(exp_q[idx].gap));
              exp_q.delete(idx);
            end
            if (kind == K_ERR) begin
              check($sformatf("ch%0d_err_active", ch), 64'(ps_active[ch]), 64'(1));
              check($sformatf("ch%0d_err_inc", ch), 64'(ps_inc[ch]), 64'(0));
            end
            if (kind == K_CLR) check($sformatf("ch%0d_clr_active", ch), 64'(ps_active[ch]), 64'(0));
            seen_pulses[ch] = 0;
          end
          prev_en[ch] = ps_en[ch]; prev_act[ch] = ps_active[ch]; prev_err[ch] = ps_error[ch];
        end
      end
    end
  end

  // Stimulus sequence.
  initial begin
    reset_n = 1'b0;
    ps_start = '0; ps_abs = '0; ps_clear = '0; ps_phase = '0;
    lock_want = '1;
    for (int ch = 0; ch < NCH; ch++) begin
      model_cur[ch] = 0; withhold[ch] = 0; drop_at[ch] = 0;
      seen_pulses[ch] = 0; last_pulse_cyc[ch] = 0;
    end
    repeat (3) tick();
    check("rst_en", 64'(ps_en), 64'(0));
    check("rst_inc", 64'(ps_inc), 64'(0));
    check("rst_active", 64'(ps_active), 64'(0));
    check("rst_error", 64'(ps_error), 64'(0));
    check("rst_current", 64'(ps_current), 64'(0));
    reset_n = 1'b1;
    repeat (2) tick();

    // Relative +3 on ch0.
    arm(0, 1'b0, 3, M_NORMAL, 0); fire(); wait_q(0);
    // Relative -5 then absolute +2 on ch1.
    arm(1, 1'b0, 12'hFFB, M_NORMAL, 0); fire(); wait_q(1);
    arm(1, 1'b1, 2, M_NORMAL, 0); fire(); wait_q(1);

    // Zero-length requests and a clear in IDLE do nothing.
    arm(1, 1'b1, 2, M_NORMAL, 0);
    arm(0, 1'b0, 0, M_NORMAL, 0);
    fire();
    ps_clear[0] = 1'b1; tick(); ps_clear[0] = 1'b0;
    repeat (6) tick();
    check("zero_active", 64'(ps_active), 64'(0));
    check("zero_cur0", cur_of(0), 64'(model_cur[0]));
    check("zero_cur1", cur_of(1), 64'(model_cur[1]));

    // Watchdog: PSDONE withheld after the first pulse.
    withhold[0] = 1;
    arm(0, 1'b0, 6, M_TIMEOUT, 0); fire(); wait_q(0);
    withhold[0] = 0;
    clear_ch(0);

    // Lock drop together with the 4th PSDONE on ch0 while ch1 runs +4.
    drop_at[0] = 4;
    arm(0, 1'b0, 10, M_DROP, 4);
    arm(1, 1'b0, 4, M_NORMAL, 0);
    fire();
    wait_q(0); wait_q(1);
    drop_at[0] = 0;
    tick();
    clear_ch(0);

    // Start with the clock unlocked goes straight to ERROR.
    lock_want[1] = 1'b0; tick(); tick();
    arm(1, 1'b0, 7, M_NORMAL, 0); fire(); wait_q(1);
    lock_want[1] = 1'b1; tick(); tick();
    clear_ch(1);

    // A start during an active run is ignored.
    arm(0, 1'b0, 8, M_NORMAL, 0); fire();
    wait_pulses(0, 2);
    ps_start[0] = 1'b1; ps_abs[0] = 1'b1; ps_phase[0 +: PB] = PB'(-300);
    tick(); ps_start = '0;
    wait_q(0);

    // Reset in the middle of a run.
    arm(0, 1'b0, 8, M_NORMAL, 0); fire();
    wait_pulses(0, 3);
    exp_q.delete();
    reset_n = 1'b0;
    tick(); tick();
    check("midrst_en", 64'(ps_en), 64'(0));
    check("midrst_active", 64'(ps_active), 64'(0));
    check("midrst_current", 64'(ps_current), 64'(0));
    for (int ch = 0; ch < NCH; ch++) model_cur[ch] = 0;
    reset_n = 1'b1;
    repeat (8) tick();
    check("postrst_active", 64'(ps_active), 64'(0));

    // Randomised concurrent traffic.
    for (int it = 0; it < 12; it++) begin
      for (int ch = 0; ch < NCH; ch++) begin
        bit a;
        a = 1'($urandom_range(0, 1));
        if (a) arm(ch, 1'b1, int'($urandom_range(0, 80)) - 40, M_NORMAL, 0);
        else   arm(ch, 1'b0, int'($urandom_range(0, 30)) - 15, M_NORMAL, 0);
      end
      fire();
      for (int ch = 0; ch < NCH; ch++) wait_q(ch);
      for (int ch = 0; ch < NCH; ch++)
        check($sformatf("rand_cur%0d", ch), cur_of(ch), 64'(model_cur[ch]));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
